// File: rtl/coeff_packer.sv
// Packs reduced 12-bit coefficients eight per 96-bit RAM word for one or two
// 256-coefficient polynomials, writing consecutive addresses from base_addr.
module coeff_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        two_poly,
  input  logic        in_valid,
  input  logic [12:0] in_coeff,
  output logic        in_ready,
  output logic        ram_wen,
  output logic [7:0]  ram_waddr,
  output logic [95:0] ram_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          SLOTS = 8;
  localparam int          CW    = 12;
  localparam logic [12:0] Q     = 13'd3329;
  localparam logic [12:0] CMAX  = 13'd6657;

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [7:0]                base_q;
  logic                      two_q;
  logic [2:0]                slot;
  logic [5:0]                word_idx;
  logic [SLOTS-1:0][CW-1:0]  pbuf, word_nxt;
  logic [12:0]               red;
  logic                      xfer, last_word, word_full;

  assign xfer      = (state == PACK) && in_valid;
  assign red       = (in_coeff >= Q) ? in_coeff - Q : in_coeff;
  assign word_full = (slot == 3'd7);
  // Last word index is 31 for one polynomial, 63 for two.
  assign last_word = (word_idx == {two_q, 5'h1f});

  // Buffer view including this cycle's coefficient, so slot 7 is written directly to RAM.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign word_nxt[k] = (xfer && slot == 3'(k)) ? red[CW-1:0] : pbuf[k];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PACK;
      PACK:    if (xfer && word_full && last_word) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == PACK);
    busy     = (state == PACK) || (state == DRAIN);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      two_q     <= 1'b0;
      slot      <= '0;
      word_idx  <= '0;
      pbuf      <= '0;
      err       <= 1'b0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_wen <= 1'b0;
      if (state == IDLE && start) begin
        base_q   <= base_addr;
        two_q    <= two_poly;
        slot     <= '0;
        word_idx <= '0;
        err      <= 1'b0;
      end
      if (xfer) begin
        pbuf <= word_nxt;
        slot <= slot + 3'd1;
        if (in_coeff > CMAX) err <= 1'b1;
        if (word_full) begin
          ram_wen   <= 1'b1;
          ram_waddr <= base_q + {2'b00, word_idx};
          ram_wdata <= word_nxt;
          word_idx  <= word_idx + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coeff_packer.sv
// Randomized bench for coeff_packer against a queue-based packing model.
module tb_coeff_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        two_poly = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_coeff = '0;
  logic        in_ready, ram_wen, busy, done, err;
  logic [7:0]  ram_waddr;
  logic [95:0] ram_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b1;
  logic [95:0] prev_wdata = '0;
  int          wr_addr[$];
  logic [95:0] wr_data[$];
  int          wr_cyc[$];

  coeff_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .two_poly(two_poly),
    .in_valid(in_valid), .in_coeff(in_coeff), .in_ready(in_ready), .ram_wen(ram_wen),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  // Write monitor; also checks that ram_wdata holds between writes.
  always @(negedge clk) begin
    if (ram_wen) begin
      wr_addr.push_back(int'(ram_waddr));
      wr_data.push_back(ram_wdata);
      wr_cyc.push_back(cyc);
    end else if (!rst_at_edge) begin
      n_cmp++;
      if (ram_wdata !== prev_wdata) begin
        n_bad++;
        $display("FAIL wdata_hold cyc=%0d got=%h exp=%h", cyc, ram_wdata, prev_wdata);
      end
    end
    prev_wdata = ram_wdata;
  end

  function automatic logic [11:0] reduce(input int c);
    return 12'(((c >= 3329) ? c - 3329 : c) % 4096);
  endfunction

  task automatic check_outputs_zero(input string tag);
    n_cmp++;
    if ({in_ready, ram_wen, ram_waddr, ram_wdata, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL %s got rdy=%b wen=%b addr=%h data=%h busy=%b done=%b err=%b exp all 0",
               tag, in_ready, ram_wen, ram_waddr, ram_wdata, busy, done, err);
    end
  endtask

  // Runs one full job and checks every write, err tracking and done timing.
  task automatic run_job(input logic [7:0] base, input bit tp, input int gap_pct,
                         input int cs[$], input bit poke);
    int n = cs.size();
    int nw = n / 8;
    int idx = 0;
    int guard = 0;
    int acc_cyc[$];
    bit merr = 1'b0;
    bit acc;
    logic [95:0] ew;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; two_poly = tp;
    @(negedge clk);
    start = 1'b0; base_addr = 8'($urandom); two_poly = ~tp;
    while (idx < n && guard < 20000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_coeff = in_valid ? 13'(cs[idx]) : 13'($urandom);
      if (poke && idx == 100) begin
        start = 1'b1; base_addr = 8'd200; two_poly = 1'b1;
      end else start = 1'b0;
      acc = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        if (cs[idx] > 6657) merr = 1'b1;
        idx++;
        n_cmp++;
        if (err !== merr) begin
          n_bad++;
          $display("FAIL err_track idx=%0d got=%b exp=%b", idx, err, merr);
        end
      end
    end
    in_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if (idx != n) begin
      n_bad++;
      $display("FAIL accept_timeout got=%0d exp=%0d", idx, n);
      return;
    end
    guard = 0;
    while (!done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    // Accept edge E -> DRAIN cycle -> DONE cycle, observed one edge after E.
    n_cmp++;
    if (!done || cyc != acc_cyc[n-1] + 1) begin
      n_bad++;
      $display("FAIL done_latency got done=%b at=%0d exp at=%0d", done, cyc, acc_cyc[n-1] + 1);
    end
    if (poke) begin
      start = 1'b1; base_addr = 8'd200; two_poly = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_done got busy=%b rdy=%b exp 0 0", busy, in_ready);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (err !== merr) begin
      n_bad++;
      $display("FAIL err_sticky got=%b exp=%b", err, merr);
    end
    n_cmp++;
    if (wr_addr.size() != nw) begin
      n_bad++;
      $display("FAIL write_count got=%0d exp=%0d", wr_addr.size(), nw);
    end
    for (int w = 0; w < nw && w < wr_addr.size(); w++) begin
      for (int k = 0; k < 8; k++) ew[12*k +: 12] = reduce(cs[8*w + k]);
      n_cmp++;
      if (wr_addr[w] != (int'(base) + w) % 256 || wr_data[w] !== ew || wr_cyc[w] != acc_cyc[8*w + 7]) begin
        n_bad++;
        $display("FAIL write_%0d got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d", w, wr_addr[w], wr_data[w],
                 wr_cyc[w], (int'(base) + w) % 256, ew, acc_cyc[8*w + 7]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = 8'hff;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_single_poly();
    int cs[$];
    logic [95:0] w0;
    for (int i = 0; i < 256; i++) cs.push_back(i);
    run_job(8'd96, 1'b0, 0, cs, 1'b0);
    w0 = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0};
    n_cmp++;
    if (wr_data.size() == 0 || wr_data[0] !== w0) begin
      n_bad++;
      $display("FAIL single_word0 got=%h exp=%h", wr_data.size() ? wr_data[0] : 96'h0, w0);
    end
  endtask

  task automatic test_reduction();
    int cs[$];
    logic [47:0] exp4;
    cs = '{3328, 3329, 6657, 6658};
    for (int i = 4; i < 256; i++) cs.push_back(int'($urandom_range(0, 6657)));
    run_job(8'd0, 1'b0, 20, cs, 1'b0);
    exp4 = {12'd3329, 12'd3328, 12'd0, 12'd3328};
    n_cmp++;
    if (wr_data.size() == 0 || wr_data[0][47:0] !== exp4) begin
      n_bad++;
      $display("FAIL reduction_slots got=%h exp=%h", wr_data.size() ? wr_data[0][47:0] : 48'h0, exp4);
    end
  endtask

  task automatic test_wrap_gaps();
    int cs[$];
    for (int i = 0; i < 512; i++) cs.push_back(int'($urandom_range(0, 6657)));
    run_job(8'd224, 1'b1, 35, cs, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    int cs[$];
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 8'd50; two_poly = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_coeff = (i == 10) ? 13'd7000 : 13'(i * 100);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_outputs_zero("reset_mid_job");
    @(negedge clk);
    check_outputs_zero("start_with_rst_ignored");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() != 1 || wr_addr[0] != 50) begin
      n_bad++;
      $display("FAIL reset_write_count got=%0d first=%0d exp=1 at 50", wr_addr.size(),
               wr_addr.size() ? wr_addr[0] : -1);
    end
    for (int i = 0; i < 256; i++) cs.push_back(int'($urandom_range(0, 8191)));
    run_job(8'd250, 1'b0, 30, cs, 1'b0);
  endtask

  task automatic test_start_ignored();
    int cs[$];
    for (int i = 0; i < 256; i++) cs.push_back(int'($urandom_range(0, 6657)));
    run_job(8'd10, 1'b0, 0, cs, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_poly();
    test_reduction();
    test_wrap_gaps();
    test_reset_mid_job();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coeff_packer.md
COEFF_PACKER -- requirements
Module: coeff_packer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle request to begin a packing job; sampled only in IDLE.
REQ-004 base_addr  input  8  RAM word address of the first packed word; captured on accepted start.
REQ-005 two_poly  input  1  0: job = 1 polynomial (32 words), 1: job = 2 polynomials (64 words); captured on accepted start.
REQ-006 in_valid  input  1  producer has a coefficient on in_coeff.
REQ-007 in_coeff  input  13  coefficient, nominal range 0..6657 (< 2q, q = 3329).
REQ-008 in_ready  output  1  block accepts in_coeff this cycle; a transfer occurs when in_valid & in_ready.
REQ-009 ram_wen  output  1  registered RAM write enable, one cycle per packed word.
REQ-010 ram_waddr  output  8  registered RAM write address.
REQ-011 ram_wdata  output  96  registered packed word, 8 x 12-bit coefficients.
REQ-012 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  sticky flag: an out-of-range coefficient was accepted in the current or last job.

Function
REQ-015 States SHALL be IDLE, PACK, DRAIN, DONE.
REQ-016 IDLE: in_ready=0, busy=0; start=1 SHALL capture base_addr and two_poly, clear word and coefficient counters, clear err, and go to PACK.
REQ-017 PACK: in_ready=1 every cycle; each transfer adds one reduced coefficient to the packing buffer.
REQ-018 Reduction: r = in_coeff - 3329 if in_coeff >= 3329, else in_coeff; the stored value is r[11:0].
REQ-019 in_coeff > 6657 SHALL set err; the stored value is (in_coeff - 3329) mod 4096; packing continues.
REQ-020 Slot order: the k-th accepted coefficient of a word (k = 0..7) SHALL occupy ram_wdata[12k+11:12k], with coefficient 0 in the LSBs.
REQ-021 On the edge accepting slot 7, the complete word SHALL be driven onto ram_wdata with ram_wen=1 and ram_waddr = base_addr + word_idx (mod 256) in the following cycle; ram_wen is otherwise 0.
REQ-022 Back-to-back transfers SHALL sustain 1 coefficient/cycle with no stall; the slot-7 transfer and the slot-0 transfer of the next word may occur on consecutive edges.
REQ-023 word_idx SHALL increment after each write; a job ends after 32 words (two_poly=0) or 64 words (two_poly=1).
REQ-024 On the edge accepting the last coefficient of the job, the state SHALL go to DRAIN, with in_ready=0 from the next cycle; DRAIN is the cycle carrying the final ram_wen=1.
REQ-025 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE; total latency from the last coefficient accept to done is 2 cycles.
REQ-026 in_valid=0 in PACK SHALL hold all state; gaps of any length are allowed.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 Address wrap: base_addr + word_idx > 255 SHALL wrap modulo 256 without error.
REQ-029 ram_wdata SHALL hold its last value when ram_wen=0.
REQ-030 err SHALL remain set after done until the next accepted start or reset.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, in_ready=0, ram_wen=0, ram_waddr=0, ram_wdata=0, busy=0, done=0, err=0, and all counters and the buffer are cleared.
REQ-032 Reset mid-job SHALL discard any partial word with no further RAM write; start in the same cycle as rst is ignored.

Verification
REQ-033 Single poly: start, base_addr=96, two_poly=0, coefficients 0..255 continuous -> 32 writes at addresses 96..127 on consecutive-cycle groups; word 0 = {7,6,5,4,3,2,1,0} packed as 12-bit fields; done 2 cycles after the last accept.
REQ-034 Reduction: coefficients 3328, 3329, 6657, 6658 -> stored 3328, 0, 3328, 3329 (mod 4096 = 3329); err=1 only after the 6658 transfer and still 1 after done.
REQ-035 Two polys with wrap: base_addr=224, two_poly=1, random in_valid gaps -> 64 writes, addresses 224..255 then 0..31; data matches the reference model; no write during a gap.
REQ-036 Reset mid-job: rst asserted after 13 accepts -> exactly 1 write (address base_addr); all outputs zero next cycle; a new job completes normally.
REQ-037 start while busy and start during DONE -> ignored; base_addr unchanged; no second job.
